instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 158 +++++++++++++++
 tb/tb_instruction_fetch.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit.
// Walks a PC through a combinational ROM, delivering one 32-bit word per
// cycle through a valid/ready handshake. An all-zero word stops fetch until
// a redirect arrives. A redirect flushes any pending word and restarts
// fetch at the word-aligned target.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] rom_address,
  output logic        rom_chip_select,
  output logic        rom_output_enable,
  input  logic [63:0] rom_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STALL  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [31:0] PC_STEP_W = 32'(PC_STEP);

  state_t      state_r, state_next_s;
  logic [31:0] pc_r, pc_next_s;
  logic [31:0] instr_r, instr_next_s;
  logic [31:0] instr_pc_r, instr_pc_next_s;
  logic        instr_valid_r, instr_valid_next_s;
  logic        halted_r, halted_next_s;
  logic        rom_en_r;
  logic        transfer_s;
  logic [31:0] target_aligned_s;
  logic [31:0] rom_word_s;
  logic [33:0] unused_bits_s;

  // The upper ROM half and the low target bits never affect fetch.
  assign unused_bits_s    = {rom_data[63:32], redirect_target[1:0]};
  assign rom_word_s       = rom_data[31:0];
  assign target_aligned_s = {redirect_target[31:2], 2'b00};
  assign transfer_s       = instr_valid_r & instr_ready;

  assign rom_address       = pc_r;
  assign rom_chip_select   = rom_en_r;
  assign rom_output_enable = rom_en_r;
  assign instr             = instr_r;
  assign instr_pc          = instr_pc_r;
  assign instr_valid       = instr_valid_r;
  assign halted            = halted_r;

  // Next-state and datapath decisions for the fetch FSM.
  always_comb begin
    state_next_s       = state_r;
    pc_next_s          = pc_r;
    instr_next_s       = instr_r;
    instr_pc_next_s    = instr_pc_r;
    instr_valid_next_s = transfer_s ? 1'b0 : instr_valid_r;
    halted_next_s      = halted_r;

    case (state_r)
      IDLE: begin
        // Nothing is captured here; a redirect only seeds the PC.
        state_next_s = FETCH;
        if (redirect) begin
          pc_next_s = target_aligned_s;
        end else begin
          pc_next_s = pc_r;
        end
      end

      FETCH: begin
        if (redirect) begin
          pc_next_s          = target_aligned_s;
          instr_valid_next_s = 1'b0;
          halted_next_s      = 1'b0;
          state_next_s       = FETCH;
        end else if (!instr_valid_r || instr_ready) begin
          if (rom_word_s != 32'h00000000) begin
            instr_next_s       = rom_word_s;
            instr_pc_next_s    = pc_r;
            instr_valid_next_s = 1'b1;
            pc_next_s          = pc_r + PC_STEP_W;
            state_next_s       = FETCH;
          end else begin
            // Zero word is the stop marker: not delivered, PC parked on it.
            halted_next_s = 1'b1;
            state_next_s  = HALTED;
          end
        end else begin
          state_next_s = STALL;
        end
      end

      STALL: begin
        if (redirect) begin
          pc_next_s          = target_aligned_s;
          instr_valid_next_s = 1'b0;
          halted_next_s      = 1'b0;
          state_next_s       = FETCH;
        end else if (instr_ready) begin
          // Consumer took the word; one bubble before the next fetch.
          instr_valid_next_s = 1'b0;
          state_next_s       = FETCH;
        end else begin
          state_next_s = STALL;
        end
      end

      HALTED: begin
        if (redirect) begin
          pc_next_s          = target_aligned_s;
          instr_valid_next_s = 1'b0;
          halted_next_s      = 1'b0;
          state_next_s       = FETCH;
        end else begin
          state_next_s = HALTED;
        end
      end

      default: begin
        state_next_s       = IDLE;
        instr_valid_next_s = 1'b0;
        halted_next_s      = 1'b0;
      end
    endcase
  end

  // State, PC and instruction holding registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      instr_r       <= 32'h00000000;
      instr_pc_r    <= 32'h00000000;
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
      rom_en_r      <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      pc_r          <= pc_next_s;
      instr_r       <= instr_next_s;
      instr_pc_r    <= instr_pc_next_s;
      instr_valid_r <= instr_valid_next_s;
      halted_r      <= halted_next_s;
      rom_en_r      <= (state_next_s == FETCH);
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small combinational ROM model.
module tb_instruction_fetch;

  logic        clock;
  logic        reset_n;
  logic [31:0] rom_address;
  logic        rom_chip_select;
  logic        rom_output_enable;
  logic [63:0] rom_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        halted;

  logic [31:0] mem [0:63];
  int checks;
  int errors;

  instruction_fetch #(.RESET_PC(32'h00000000), .PC_STEP(4)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .rom_address(rom_address),
    .rom_chip_select(rom_chip_select),
    .rom_output_enable(rom_output_enable),
    .rom_data(rom_data),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .halted(halted)
  );

  // Combinational ROM; upper half carries junk that must be ignored.
  assign rom_data = (rom_chip_select && rom_output_enable) ?
                    {32'hDEADBEEF, mem[rom_address[7:2]]} : 64'hz;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    redirect = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_target = 32'h0;
    #3;
    checks++; if (rom_address !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", rom_address, 32'h0); end
    checks++; if ({rom_chip_select, rom_output_enable} !== 2'b00) begin errors++; $display("FAIL reset_cs got %b exp 00", {rom_chip_select, rom_output_enable}); end
    checks++; if ({instr_valid, halted} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {instr_valid, halted}); end
    checks++; if ({instr, instr_pc} !== 64'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", {instr, instr_pc}); end
  endtask

  task automatic test_basic();
    do_reset();
    checks++; if (rom_chip_select !== 1'b0) begin errors++; $display("FAIL idle_cs got %b exp 0", rom_chip_select); end
    tick();
    checks++; if ({rom_chip_select, rom_address} !== {1'b1, 32'h0}) begin errors++; $display("FAIL first_fetch got %h exp %h", {rom_chip_select, rom_address}, {1'b1, 32'h0}); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_nocapture got %b exp 0", instr_valid); end
    tick();
    checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hD2FFFFE0, 32'h0}) begin errors++; $display("FAIL basic_w0 got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, 32'hD2FFFFE0, 32'h0}); end
    tick();
    checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hF2B55540, 32'h4}) begin errors++; $display("FAIL basic_w1 got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, 32'hF2B55540, 32'h4}); end
    tick();
    checks++; if ({halted, instr_valid} !== 2'b10) begin errors++; $display("FAIL basic_halt got %b exp 10", {halted, instr_valid}); end
    checks++; if ({rom_chip_select, rom_output_enable, rom_address} !== {2'b00, 32'h8}) begin errors++; $display("FAIL basic_halt_addr got %h exp %h", {rom_chip_select, rom_output_enable, rom_address}, {2'b00, 32'h8}); end
    tick();
    checks++; if ({halted, rom_chip_select, rom_address} !== {2'b10, 32'h8}) begin errors++; $display("FAIL halt_hold got %h exp %h", {halted, rom_chip_select, rom_address}, {2'b10, 32'h8}); end
  endtask

  task automatic test_redirect_halted();
    redirect = 1'b1; redirect_target = 32'h00000010;
    tick();
    redirect = 1'b0;
    checks++; if ({halted, rom_chip_select, rom_address} !== {2'b01, 32'h10}) begin errors++; $display("FAIL halt_redirect got %h exp %h", {halted, rom_chip_select, rom_address}, {2'b01, 32'h10}); end
    tick();
    checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h11111111, 32'h10}) begin errors++; $display("FAIL halt_resume got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, 32'h11111111, 32'h10}); end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hD2FFFFE0, 32'h0}) begin errors++; $display("FAIL stall_hold%0d got %h exp %h", i, {instr_valid, instr, instr_pc}, {1'b1, 32'hD2FFFFE0, 32'h0}); end
      checks++; if ({rom_chip_select, rom_address} !== {1'b0, 32'h4}) begin errors++; $display("FAIL stall_cs%0d got %h exp %h", i, {rom_chip_select, rom_address}, {1'b0, 32'h4}); end
    end
    instr_ready = 1'b1;
    tick();
    checks++; if ({instr_valid, rom_chip_select, rom_address} !== {2'b01, 32'h4}) begin errors++; $display("FAIL stall_bubble got %h exp %h", {instr_valid, rom_chip_select, rom_address}, {2'b01, 32'h4}); end
    tick();
    checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hF2B55540, 32'h4}) begin errors++; $display("FAIL stall_next got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, 32'hF2B55540, 32'h4}); end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    tick();
    tick();
    instr_ready = 1'b0;
    tick();
    checks++; if ({instr_valid, rom_chip_select} !== 2'b10) begin errors++; $display("FAIL rs_stall got %b exp 10", {instr_valid, rom_chip_select}); end
    instr_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h00000103;
    tick();
    redirect = 1'b0;
    checks++; if ({instr_valid, rom_chip_select, rom_address} !== {2'b01, 32'h100}) begin errors++; $display("FAIL rs_flush got %h exp %h", {instr_valid, rom_chip_select, rom_address}, {2'b01, 32'h100}); end
    tick();
    checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hD2FFFFE0, 32'h100}) begin errors++; $display("FAIL rs_fetch got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, 32'hD2FFFFE0, 32'h100}); end
  endtask

  task automatic test_wrap();
    instr_ready = 1'b1; redirect = 1'b1; redirect_target = 32'hFFFFFFFC;
    tick();
    redirect = 1'b0;
    checks++; if (rom_address !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_addr got %h exp %h", rom_address, 32'hFFFFFFFC); end
    tick();
    checks++; if ({instr, instr_pc} !== {32'hAAAA5555, 32'hFFFFFFFC}) begin errors++; $display("FAIL wrap_w0 got %h exp %h", {instr, instr_pc}, {32'hAAAA5555, 32'hFFFFFFFC}); end
    tick();
    checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hD2FFFFE0, 32'h0}) begin errors++; $display("FAIL wrap_w1 got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, 32'hD2FFFFE0, 32'h0}); end
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ar_pre got %b exp 1", instr_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({instr_valid, halted, rom_chip_select, rom_output_enable} !== 4'b0000) begin errors++; $display("FAIL ar_flags got %b exp 0000", {instr_valid, halted, rom_chip_select, rom_output_enable}); end
    checks++; if ({rom_address, instr, instr_pc} !== 96'h0) begin errors++; $display("FAIL ar_regs got %h exp 0", {rom_address, instr, instr_pc}); end
    #1;
    reset_n = 1'b1; instr_ready = 1'b1;
    tick();
    checks++; if ({rom_chip_select, rom_address} !== {1'b1, 32'h0}) begin errors++; $display("FAIL ar_restart got %h exp %h", {rom_chip_select, rom_address}, {1'b1, 32'h0}); end
    tick();
    checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'hD2FFFFE0, 32'h0}) begin errors++; $display("FAIL ar_fetch got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, 32'hD2FFFFE0, 32'h0}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h01000000 + 32'(i);
    mem[0]  = 32'hD2FFFFE0;
    mem[1]  = 32'hF2B55540;
    mem[2]  = 32'h00000000;
    mem[4]  = 32'h11111111;
    mem[63] = 32'hAAAA5555;
    test_reset();
    test_basic();
    test_redirect_halted();
    test_stall();
    test_redirect_stall();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
